demux_stream_1n: RTL and testbench
==================================

Name: demux_stream_1n

Overview:
- Registered 1-to-N stream demultiplexer with valid/ready handshake; parametrised successor of the combinational 1-to-2 demux.
- Routes each WIDTH-bit input beat to one of N output channels selected by sel.
- One-entry output register gives 1-cycle latency and full throughput under back-pressure.
- Sits between a single producer and N consumers in the datapath library.

Parameters:
- WIDTH, 8, data width per beat (>=1)
- N, 4, number of output channels (>=2; need not be a power of 2)
- SW, $clog2(N), select width; localparam derived from N, not overridable

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  producer has a beat
- in_ready  output  1  block can accept a beat this cycle
- in_data  input  WIDTH  beat payload
- sel  input  SW  destination channel, sampled with the beat
- out_valid  output  N  one-hot; bit k = beat held for channel k
- out_ready  input  N  per-channel consumer ready
- out_data  output  N*WIDTH  lane k = bits [k*WIDTH +: WIDTH]
- err  output  1  1-cycle pulse: beat with sel >= N accepted and dropped

Behaviour:
- State: full_q, data_q[WIDTH], sel_q[SW]. Reset (rst=1 at clk edge): full_q=0, data_q=0, sel_q=0, err=0. All outputs then read: out_valid=0, out_data=0, in_ready=1.
- Accept: in_valid && in_ready.
- Pop: full_q && out_ready[sel_q].
- in_ready = !full_q || out_ready[sel_q] (combinational; pass-through pop+push allowed).
- On accept with sel < N: data_q<=in_data, sel_q<=sel, full_q<=1. Visible on out_valid exactly 1 cycle after acceptance.
- On pop without accept: full_q<=0.
- On simultaneous pop and accept: the new beat replaces the old one with no bubble; full_q stays 1.
- On accept with sel >= N: beat is consumed and discarded, full_q unchanged/cleared by pop as normal, err=1 for the next cycle only. Only possible when N is not a power of 2.
- out_valid = full_q ? (1<<sel_q) : 0.
- out_data: selected lane = data_q; every unselected lane = 0. All lanes = 0 when !full_q.
- out_ready bits of non-selected channels are ignored.
- Once out_valid is raised, out_data/out_valid hold stable until popped. No retraction without pop, except on reset.
- rst mid-operation: the held beat is discarded. out_valid=0 from the cycle after the reset edge. rst overrides accept/pop in the same cycle.
- in_valid=0: no state change except pop.

Optional Feature:
- Macro DEMUX_RR_EN.
- Defined: sel port is ignored. An internal round-robin pointer rr_q[SW] (reset 0) supplies the destination. rr_q advances by 1 on each accept and wraps from N-1 to 0. err is tied to 0.
- Undefined: rr_q does not exist; routing follows sel as above.

Decomposition:
- Package demux_pkg: function onehot_dec(idx, N), localparam default widths, and the lane-slicing macro/function used for out_data.
- One natural sub-module: demux_onehot_dec (SW -> N one-hot decoder with out-of-range flag). It is reused for out_valid generation and err detection.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_data=0, in_ready=1, err=0 throughout.
- Basic route (N=4, W=8): in_data=8'hA5, sel=2, all out_ready=1 -> next cycle out_valid=4'b0100, lane2=8'hA5, other lanes 0.
- Back-pressure: hold beat 8'h3C to sel=1 with out_ready[1]=0 for 3 cycles, out_ready[0]=1 -> in_ready=0, out_valid=4'b0010 stable, data stable. Raise out_ready[1] -> pop plus pass-through accept of next beat, no bubble.
- Streaming: 8 back-to-back beats 0..7 with sel=i%4, all ready -> one beat per cycle, channel i%4 receives i, latency 1.
- Out of range (N=3): sel=3 beat 8'hFF -> accepted, err pulses 1 cycle, out_valid stays 0. Reset mid-hold with full_q=1 -> out_valid=0 next cycle.
- DEMUX_RR_EN (N=3): 5 beats with sel forced to 0 -> delivered to channels 0,1,2,0,1. rst then resets the pointer so the next beat goes to channel 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types, default sizes and helpers for the 1-to-N stream demultiplexer.
package demux_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_N     = 4;
  localparam int unsigned MAX_N     = 64;

  // One-hot decode of idx into the low n bits; out-of-range idx yields all zeros.
  function automatic logic [MAX_N-1:0] onehot_dec(input int unsigned idx, input int unsigned n);
    logic [MAX_N-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_N; i++) begin
      v[i] = (i == idx) && (i < n);
    end
    return v;
  endfunction

  // Low bit of lane k in a packed multi-lane bus.
  function automatic int unsigned lane_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/demux_onehot_dec.sv
// SW -> N one-hot decoder with an out-of-range flag for non-power-of-2 N.
module demux_onehot_dec
  import demux_pkg::*;
#(
  parameter  int unsigned N  = DEF_N,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic [SW-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          oor
);

  always_comb begin
    onehot = N'(onehot_dec(32'(idx), N));
    oor    = (32'(idx) >= N);
  end

endmodule

// File: rtl/demux_stream_1n.sv
// Registered 1-to-N valid/ready stream demultiplexer with one-entry output stage.
// Build option DEMUX_RR_EN: destination from an internal round-robin pointer instead of sel.
module demux_stream_1n
  import demux_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned N     = DEF_N,
  localparam int unsigned SW    = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SW-1:0]      sel,
  output logic [N-1:0]       out_valid,
  input  logic [N-1:0]       out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               err
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic             err_q, err_d;

  logic [SW-1:0]    dest;
  logic [N-1:0]     dest_oh;
  logic             dest_oor;
  logic [N-1:0]     held_oh;
  logic             held_oor;
  logic             accept;
  logic             pop;

`ifdef DEMUX_RR_EN
  logic [SW-1:0] rr_q;
  logic          unused_sel;

  assign dest       = rr_q;
  assign unused_sel = ^sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else if (accept) begin
      rr_q <= (rr_q == SW'(N - 1)) ? '0 : rr_q + 1'b1;
    end
  end
`else
  assign dest = sel;
`endif

  demux_onehot_dec #(.N(N)) u_dest_dec (
    .idx    (dest),
    .onehot (dest_oh),
    .oor    (dest_oor)
  );

  demux_onehot_dec #(.N(N)) u_held_dec (
    .idx    (sel_q),
    .onehot (held_oh),
    .oor    (held_oor)
  );

  logic unused_dec;
  assign unused_dec = held_oor ^ (^dest_oh);

  assign out_valid = full_q ? held_oh : '0;
  // Only the held channel's ready matters, so masking with out_valid ignores the rest.
  assign pop       = |(out_valid & out_ready);
  assign in_ready  = !full_q || pop;
  assign accept    = in_valid && in_ready;
  assign err       = err_q;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    sel_d  = sel_q;
    if (accept && !dest_oor) begin
      full_d = 1'b1;
      data_d = in_data;
      sel_d  = dest;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_comb begin
    err_d = 1'b0;
`ifndef DEMUX_RR_EN
    err_d = accept && dest_oor;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      sel_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (out_valid[k]) begin
        out_data[lane_lo(k, WIDTH) +: WIDTH] = data_q;
      end
    end
  end

endmodule

// File: tb/tb_demux_stream_1n.sv
// Directed self-checking bench for demux_stream_1n (N=4 and N=3 instances).
module tb_demux_stream_1n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=4, WIDTH=8 instance
  logic        in_valid4, in_ready4, err4;
  logic [7:0]  in_data4;
  logic [1:0]  sel4;
  logic [3:0]  out_valid4, out_ready4;
  logic [31:0] out_data4;

  // N=3, WIDTH=8 instance
  logic        in_valid3, in_ready3, err3;
  logic [7:0]  in_data3;
  logic [1:0]  sel3;
  logic [2:0]  out_valid3, out_ready3;
  logic [23:0] out_data3;

  int n_checks = 0;
  int n_errors = 0;

  demux_stream_1n #(.WIDTH(8), .N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .sel       (sel4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .err       (err4)
  );

  demux_stream_1n #(.WIDTH(8), .N(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .sel       (sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .err       (err3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid4 = 1'b1; in_data4 = 8'hFF; sel4 = 2'd1; out_ready4 = 4'h0;
    in_valid3 = 1'b1; in_data3 = 8'hFF; sel3 = 2'd1; out_ready3 = 3'h0;

    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_valid4", 64'(out_valid4), 64'h0);
      check("rst_data4",  64'(out_data4),  64'h0);
      check("rst_ready4", 64'(in_ready4),  64'h1);
      check("rst_err4",   64'(err4),       64'h0);
      check("rst_valid3", 64'(out_valid3), 64'h0);
    end
    rst = 1'b0;
    in_valid4 = 1'b0;
    in_valid3 = 1'b0;
    tick();

`ifdef DEMUX_RR_EN
    out_ready3 = 3'b111;
    for (int i = 0; i < 5; i++) begin
      in_valid3 = 1'b1; in_data3 = 8'(8'h10 + i); sel3 = 2'd0;
      tick();
      check("rr_valid", 64'(out_valid3), 64'(1) << (i % 3));
      check("rr_data",  64'(out_data3),  64'(8'h10 + i) << (8 * (i % 3)));
      check("rr_err",   64'(err3),       64'h0);
    end
    in_valid3 = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_rst_valid", 64'(out_valid3), 64'h0);
    in_valid3 = 1'b1; in_data3 = 8'h99; sel3 = 2'd2;
    tick();
    in_valid3 = 1'b0;
    check("rr_after_rst_valid", 64'(out_valid3), 64'h1);
    check("rr_after_rst_data",  64'(out_data3),  64'h99);
`else
    // Basic route
    out_ready4 = 4'hF;
    in_valid4 = 1'b1; in_data4 = 8'hA5; sel4 = 2'd2;
    tick();
    in_valid4 = 1'b0;
    check("basic_valid", 64'(out_valid4), 64'h4);
    check("basic_data",  64'(out_data4),  64'h00A5_0000);
    tick();
    check("basic_drain", 64'(out_valid4), 64'h0);

    // Back-pressure with pass-through
    out_ready4 = 4'b0001;
    in_valid4 = 1'b1; in_data4 = 8'h3C; sel4 = 2'd1;
    tick();
    in_data4 = 8'h5A; sel4 = 2'd3;
    #1;
    check("bp_ready", 64'(in_ready4),  64'h0);
    check("bp_valid", 64'(out_valid4), 64'h2);
    check("bp_data",  64'(out_data4),  64'h0000_3C00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 64'(out_valid4), 64'h2);
      check("bp_hold_data",  64'(out_data4),  64'h0000_3C00);
      check("bp_hold_ready", 64'(in_ready4),  64'h0);
    end
    out_ready4 = 4'b0011;
    #1;
    check("bp_release_ready", 64'(in_ready4), 64'h1);
    tick();
    in_valid4 = 1'b0;
    check("pt_valid", 64'(out_valid4), 64'h8);
    check("pt_data",  64'(out_data4),  64'h5A00_0000);
    out_ready4 = 4'hF;
    tick();
    check("pt_drain", 64'(out_valid4), 64'h0);

    // Streaming
    for (int i = 0; i < 8; i++) begin
      in_valid4 = 1'b1; in_data4 = 8'(i); sel4 = 2'(i % 4);
      #1;
      check("stream_ready", 64'(in_ready4), 64'h1);
      tick();
      check("stream_valid", 64'(out_valid4), 64'(1) << (i % 4));
      check("stream_data",  64'(out_data4),  64'(i) << (8 * (i % 4)));
    end
    in_valid4 = 1'b0;
    tick();
    check("stream_drain", 64'(out_valid4), 64'h0);

    // Out of range on N=3
    out_ready3 = 3'b111;
    in_valid3 = 1'b1; in_data3 = 8'hFF; sel3 = 2'd3;
    #1;
    check("oor_ready", 64'(in_ready3), 64'h1);
    tick();
    in_valid3 = 1'b0;
    check("oor_err",   64'(err3),       64'h1);
    check("oor_valid", 64'(out_valid3), 64'h0);
    tick();
    check("oor_err_pulse", 64'(err3), 64'h0);

    // Reset while holding a beat
    out_ready3 = 3'b000;
    in_valid3 = 1'b1; in_data3 = 8'h77; sel3 = 2'd1;
    tick();
    in_valid3 = 1'b0;
    check("hold3_valid", 64'(out_valid3), 64'h2);
    check("hold3_data",  64'(out_data3),  64'h00_7700);
    check("hold3_ready", 64'(in_ready3),  64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(out_valid3), 64'h0);
    check("midrst_data",  64'(out_data3),  64'h0);
    check("midrst_ready", 64'(in_ready3),  64'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
